// File: rtl/lms_update_engine.sv
// Time-multiplexed LMS coefficient updater: one tap per cycle, 2-stage pipe.
// Ports: i_clk/i_rst_n/i_clear, x delay-line push (i_x, i_x_valid, o_x_ready),
//   update request (i_error, i_mu, i_leak_en, i_err_valid, o_ready),
//   completion (o_done, o_sat) and the coefficient bank o_w.
module lms_update_engine #(
    parameter int N_TAPS     = 8,
    parameter int NB_I       = 18,
    parameter int NBF_I      = 15,
    parameter int NB_ERROR   = 19,
    parameter int NBF_ERROR  = 15,
    parameter int NB         = 8,
    parameter int NBF        = 7,
    parameter int NB_MU      = 16,
    parameter int LEAK_SHIFT = 10,
    parameter int ROUND      = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic [NB_I-1:0]      i_x,
    input  logic                 i_x_valid,
    output logic                 o_x_ready,
    input  logic [NB_ERROR-1:0]  i_error,
    input  logic [NB_MU-1:0]     i_mu,
    input  logic                 i_leak_en,
    input  logic                 i_err_valid,
    output logic                 o_ready,
    output logic                 o_done,
    output logic                 o_sat,
    output logic [N_TAPS*NB-1:0] o_w
);

    localparam int WM = NB_ERROR + NB_MU;
    localparam int W  = WM + NB_I;
    localparam int F  = NBF_ERROR + NB_MU - 1 + NBF_I;
    localparam int SH = F - NBF;
    localparam int WV = W + 2;
    localparam int WQ = WV - SH;
    localparam int KW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

    localparam logic signed [WV-1:0] RND_C =
        (ROUND != 0) ? (WV'(1) <<< (SH - 1)) : '0;
    localparam logic signed [WQ-1:0] QMAX = (WQ'(1) <<< (NB - 1)) - WQ'(1);
    localparam logic signed [WQ-1:0] QMIN = -QMAX - WQ'(1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t                     state;
    logic signed [NB_I-1:0]     x_q [N_TAPS];
    logic signed [NB-1:0]       w_q [N_TAPS];
    logic signed [NB_ERROR-1:0] e_q;
    logic signed [NB_MU-1:0]    mu_q;
    logic                       leak_q;
    logic signed [WM-1:0]       m1_q;
    logic signed [W-1:0]        p_q;
    logic [KW-1:0]              k_q;
    logic [KW-1:0]              pk_q;
    logic                       p_vld;
    logic                       sat_acc;

    logic signed [WV-1:0] w_ext;
    logic signed [WV-1:0] p_ext;
    logic signed [WV-1:0] v;
    logic signed [WV-1:0] v_r;
    logic signed [WQ-1:0] q;
    logic signed [NB-1:0] w_new;
    logic                 sat_now;

    assign o_ready   = (state == IDLE);
    assign o_x_ready = (state == IDLE);

    for (genvar g = 0; g < N_TAPS; g++) begin : g_w
        assign o_w[g*NB +: NB] = w_q[g];
    end

    // Write-back stage: align w to the product's binary point, subtract,
    // round, drop fractional bits and clamp to the coefficient range.
    always_comb begin
        w_ext   = WV'(w_q[pk_q]) <<< SH;
        p_ext   = WV'(p_q);
        v       = w_ext - p_ext;
        if (leak_q)
            v = v - (w_ext >>> LEAK_SHIFT);
        v_r     = v + RND_C;
        q       = WQ'(v_r >>> SH);
        sat_now = 1'b0;
        w_new   = q[NB-1:0];
        if (q > QMAX) begin
            w_new   = {1'b0, {(NB-1){1'b1}}};
            sat_now = 1'b1;
        end else if (q < QMIN) begin
            w_new   = {1'b1, {(NB-1){1'b0}}};
            sat_now = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            for (int i = 0; i < N_TAPS; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
            e_q     <= '0;
            mu_q    <= '0;
            leak_q  <= 1'b0;
            m1_q    <= '0;
            p_q     <= '0;
            k_q     <= '0;
            pk_q    <= '0;
            p_vld   <= 1'b0;
            sat_acc <= 1'b0;
            o_done  <= 1'b0;
            o_sat   <= 1'b0;
        end else if (i_clear) begin
            state   <= IDLE;
            for (int i = 0; i < N_TAPS; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
            k_q     <= '0;
            p_vld   <= 1'b0;
            sat_acc <= 1'b0;
            o_done  <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_sat  <= 1'b0;
            if (p_vld) begin
                w_q[pk_q] <= w_new;
                sat_acc   <= sat_acc | sat_now;
            end
            unique case (state)
                IDLE: begin
                    // Shift first; an update accepted now sees the new line.
                    if (i_x_valid) begin
                        x_q[0] <= i_x;
                        for (int i = 1; i < N_TAPS; i++)
                            x_q[i] <= x_q[i-1];
                    end
                    if (i_err_valid) begin
                        e_q    <= i_error;
                        mu_q   <= i_mu;
                        leak_q <= i_leak_en;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    m1_q    <= WM'(e_q) * WM'(mu_q);
                    k_q     <= '0;
                    sat_acc <= 1'b0;
                    state   <= RUN;
                end
                RUN: begin
                    p_q   <= W'(m1_q) * W'(x_q[k_q]);
                    pk_q  <= k_q;
                    p_vld <= 1'b1;
                    k_q   <= k_q + 1'b1;
                    if (k_q == KW'(N_TAPS - 1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    p_vld  <= 1'b0;
                    o_done <= 1'b1;
                    o_sat  <= sat_acc | sat_now;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_update_engine.sv
// Randomized bench for lms_update_engine against a plain-arithmetic model.
// Directed cases cover defaults, saturation, rounding, leakage, clear, reset.
module tb_lms_update_engine;

    localparam int N  = 8;
    localparam int LS = 3;
    localparam int RND = 1;
    localparam int SH = 38;

    logic              clk = 0;
    logic              rst_n = 0;
    logic              i_clear = 0;
    logic [17:0]       i_x = '0;
    logic              i_x_valid = 0;
    logic              o_x_ready;
    logic [18:0]       i_error = '0;
    logic [15:0]       i_mu = '0;
    logic              i_leak_en = 0;
    logic              i_err_valid = 0;
    logic              o_ready;
    logic              o_done;
    logic              o_sat;
    logic [N*8-1:0]    o_w;

    int n_chk = 0;
    int n_pass = 0;
    longint xm [N];
    longint wm [N];

    lms_update_engine #(.LEAK_SHIFT(LS), .ROUND(RND)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(i_clear),
        .i_x(i_x), .i_x_valid(i_x_valid), .o_x_ready(o_x_ready),
        .i_error(i_error), .i_mu(i_mu), .i_leak_en(i_leak_en),
        .i_err_valid(i_err_valid), .o_ready(o_ready),
        .o_done(o_done), .o_sat(o_sat), .o_w(o_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_zero();
        for (int k = 0; k < N; k++) begin
            xm[k] = 0;
            wm[k] = 0;
        end
    endtask

    task automatic model_shift(input logic signed [17:0] xv);
        for (int k = N - 1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = longint'(xv);
    endtask

    // w <- w(1 - leak) - mu*e*x in real-valued terms, scaled by 2^45.
    task automatic model_update(input longint e, input longint mu,
                                input bit leak, output bit sat);
        longint wx, v, q;
        sat = 0;
        for (int k = 0; k < N; k++) begin
            wx = wm[k] * (longint'(1) << SH);
            v = wx - e * mu * xm[k];
            if (leak) v = v - (wx >>> LS);
            if (RND != 0) v = v + (longint'(1) << (SH - 1));
            q = v >>> SH;
            if (q > 127) begin q = 127; sat = 1; end
            else if (q < -128) begin q = -128; sat = 1; end
            wm[k] = q;
        end
    endtask

    task automatic check_w(input string tag);
        for (int k = 0; k < N; k++)
            check($sformatf("%s_w%0d", tag, k),
                  longint'(o_w[k*8 +: 8]), wm[k] & 255);
    endtask

    task automatic push(input logic signed [17:0] xv);
        i_x = xv;
        i_x_valid = 1;
        model_shift(xv);
        @(negedge clk);
        i_x_valid = 0;
    endtask

    task automatic pulse_clear();
        i_clear = 1;
        @(negedge clk);
        i_clear = 0;
        model_zero();
    endtask

    task automatic request(input logic signed [18:0] e,
                           input logic signed [15:0] mu, input bit leak,
                           input bit with_x, input logic signed [17:0] xv,
                           input bit hammer, input string tag);
        bit esat, done, bad;
        int cyc;
        i_error = e;
        i_mu = mu;
        i_leak_en = leak;
        i_err_valid = 1;
        if (with_x) begin
            i_x = xv;
            i_x_valid = 1;
            model_shift(xv);
        end
        model_update(longint'(e), longint'(mu), leak, esat);
        @(negedge clk);
        i_err_valid = 0;
        i_x_valid = 0;
        cyc = 0;
        done = 0;
        bad = 0;
        while (!done && cyc < 40) begin
            if (o_ready !== 1'b0 || o_x_ready !== 1'b0 || o_done !== 1'b0)
                bad = 1;
            if (hammer) begin
                i_x = 18'($urandom);
                i_x_valid = 1;
            end
            @(negedge clk);
            i_x_valid = 0;
            cyc++;
            if (o_done === 1'b1) done = 1;
        end
        check({tag, "_lat"}, cyc, N + 2);
        check({tag, "_busy"}, bad, 0);
        check({tag, "_sat"}, o_sat, esat);
        check({tag, "_rdy"}, o_ready, 1);
        check_w(tag);
        @(negedge clk);
        check({tag, "_done_clr"}, {o_done, o_sat}, 0);
    endtask

    initial begin
        logic signed [18:0] re;
        logic signed [15:0] rmu;
        logic signed [17:0] rx;
        int seen;
        model_zero();
        repeat (3) @(negedge clk);
        check("rst_w", (o_w == '0), 1);
        check("rst_hs", {o_ready, o_x_ready, o_done, o_sat}, 4'b1100);
        rst_n = 1;
        @(negedge clk);

        push(18'sh04000);
        request(19'sh02000, 16'sh4000, 0, 0, '0, 0, "t2");
        check("t2_w0c", o_w[7:0], 8'hF8);
        check("t2_restc", (o_w[N*8-1:8] == '0), 1);

        pulse_clear();
        push(18'sh07FFF);
        request(19'h68000, 16'sh7FFF, 0, 0, '0, 0, "t3");
        check("t3_w0c", o_w[7:0], 8'h7F);

        pulse_clear();
        push(18'sh04000);
        request(19'h7FA00, 16'sh4000, 0, 0, '0, 0, "t4");
        check("t4_w0c", o_w[7:0], 8'h02);

        pulse_clear();
        push(18'sh04000);
        request(19'h70000, 16'sh4000, 0, 0, '0, 0, "t5a");
        check("t5_w0a", o_w[7:0], 8'h40);
        request(19'h00000, 16'sh4000, 1, 0, '0, 0, "t5b");
        check("t5_w0b", o_w[7:0], 8'h38);

        // back-pressure plus push coinciding with acceptance
        request(19'sh01000, 16'sh2000, 0, 1, 18'sh03000, 1, "bp");
        request(-19'sh00800, 16'sh4000, 0, 0, '0, 0, "bp2");

        // abort at cycle 4
        push(18'sh04000);
        i_error = 19'h70000;
        i_mu = 16'sh4000;
        i_err_valid = 1;
        @(negedge clk);
        i_err_valid = 0;
        repeat (3) @(negedge clk);
        i_clear = 1;
        i_x = 18'sh01234;
        i_x_valid = 1;
        @(negedge clk);
        i_clear = 0;
        i_x_valid = 0;
        model_zero();
        check("clr_hs", {o_ready, o_x_ready, o_done, o_sat}, 4'b1100);
        check("clr_w", (o_w == '0), 1);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (o_done) seen++;
        end
        check("clr_nodone", seen, 0);
        request(19'h70000, 16'sh4000, 0, 0, '0, 0, "clrx");
        push(18'sh04000);
        request(19'h70000, 16'sh4000, 0, 0, '0, 0, "post");

        // asynchronous reset mid-update
        i_error = 19'h68000;
        i_mu = 16'sh7FFF;
        i_err_valid = 1;
        @(negedge clk);
        i_err_valid = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("arst_w", (o_w == '0), 1);
        check("arst_hs", {o_ready, o_done}, 2'b10);
        @(negedge clk);
        rst_n = 1;
        model_zero();
        @(negedge clk);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 7) == 0) pulse_clear();
            repeat ($urandom_range(0, 3)) begin
                rx = 18'($urandom);
                push(rx >>> $urandom_range(0, 6));
            end
            re = 19'($urandom);
            re = re >>> $urandom_range(0, 10);
            rmu = 16'($urandom);
            rmu = rmu >>> $urandom_range(0, 8);
            rx = 18'($urandom);
            request(re, rmu, 1'($urandom), 1'($urandom), rx >>> 4,
                    1'($urandom), $sformatf("r%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
